riscv_cpu: RTL and testbench

Multi-cycle RV32I integer core for the small FPGA SoC. It fetches one 32-bit instruction per step from a combinational instruction port. Data memory is a synchronous word-addressed RAM with one read cycle of latency and per-byte write enables. Loads take 2 clocks; every other instruction takes 1.

---
 rtl/riscv_pkg.sv | 48 ++++
 rtl/riscv_alu.sv | 36 +++
 rtl/riscv_cpu.sv | 238 +++++++++++++++++++++++
 tb/tb_riscv_cpu.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared encodings for the multi-cycle RV32I core.
//   - major opcode constants
//   - funct3 codes for loads, stores, branches and the ALU
//   - core FSM state enum
package riscv_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SLL  = 3'b001;
  localparam logic [2:0] ALU_SLT  = 3'b010;
  localparam logic [2:0] ALU_SLTU = 3'b011;
  localparam logic [2:0] ALU_XOR  = 3'b100;
  localparam logic [2:0] ALU_SR   = 3'b101;
  localparam logic [2:0] ALU_OR   = 3'b110;
  localparam logic [2:0] ALU_AND  = 3'b111;

  typedef enum logic [0:0] {
    EXEC    = 1'b0,
    LOAD_WB = 1'b1
  } state_e;

endpackage

// File: rtl/riscv_alu.sv
// riscv_alu: combinational integer ALU shared by OP and OP-IMM.
// Ports:
//   a_i, b_i   operands (b_i is rs2 or the I-immediate)
//   funct3_i   operation select
//   alt_i      funct7 bit 5: SUB instead of ADD, SRA instead of SRL
//   result_o   32-bit result
module riscv_alu
  import riscv_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [2:0]  funct3_i,
  input  logic        alt_i,
  output logic [31:0] result_o
);

  always_comb begin
    result_o = '0;
    case (funct3_i)
      ALU_ADD:  result_o = alt_i ? (a_i - b_i) : (a_i + b_i);
      ALU_SLL:  result_o = a_i << b_i[4:0];
      ALU_SLT:  result_o = {31'b0, ($signed(a_i) < $signed(b_i))};
      ALU_SLTU: result_o = {31'b0, (a_i < b_i)};
      ALU_XOR:  result_o = a_i ^ b_i;
      ALU_SR: begin
        // Kept as separate branches so the arithmetic shift stays signed.
        if (alt_i) result_o = $unsigned($signed(a_i) >>> b_i[4:0]);
        else       result_o = a_i >> b_i[4:0];
      end
      ALU_OR:   result_o = a_i | b_i;
      ALU_AND:  result_o = a_i & b_i;
      default:  result_o = '0;
    endcase
  end

endmodule

// File: rtl/riscv_cpu.sv
// riscv_cpu: multi-cycle RV32I core. Loads take two clocks (EXEC, LOAD_WB),
// every other instruction completes in one EXEC clock.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   inst_addr    byte address of current instruction (== pc)
//   inst_data    instruction word at inst_addr (combinational port)
//   data_addr    word address into data RAM (EA >> 2)
//   data_rd      RAM read word, valid one clock after data_addr
//   data_wr      store data replicated across byte lanes
//   data_wr_en   byte-lane write strobes
module riscv_cpu
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] inst_addr,
  input  logic [31:0] inst_data,
  output logic [31:0] data_addr,
  input  logic [31:0] data_rd,
  output logic [31:0] data_wr,
  output logic [3:0]  data_wr_en
);

  // Architectural state; names are fixed because benches reach them hierarchically.
  logic [31:0] pc;
  logic [31:0] xreg [0:31];

  state_e      state_q, state_d;
  logic [31:0] pc_d;

  // Load context captured in EXEC and consumed in LOAD_WB.
  logic [2:0]  ld_f3_q;
  logic [1:0]  ld_lane_q;
  logic [4:0]  ld_rd_q;
  logic [29:0] ld_addr_q;

  logic [6:0]  opcode, funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] rs1_val, rs2_val;
  logic [31:0] ea_i, ea;
  logic [31:0] alu_b, alu_res;
  logic        alu_alt;
  logic        op_valid, opimm_valid, load_valid;
  logic        br_valid, br_taken;
  logic        rd_we, load_start;
  logic [4:0]  wr_idx;
  logic [31:0] rd_wdata;
  logic [3:0]  store_lanes;

  assign opcode = inst_data[6:0];
  assign rd     = inst_data[11:7];
  assign funct3 = inst_data[14:12];
  assign rs1    = inst_data[19:15];
  assign rs2    = inst_data[24:20];
  assign funct7 = inst_data[31:25];

  assign imm_i = {{20{inst_data[31]}}, inst_data[31:20]};
  assign imm_s = {{20{inst_data[31]}}, inst_data[31:25], inst_data[11:7]};
  assign imm_b = {{20{inst_data[31]}}, inst_data[7], inst_data[30:25], inst_data[11:8], 1'b0};
  assign imm_u = {inst_data[31:12], 12'b0};
  assign imm_j = {{12{inst_data[31]}}, inst_data[19:12], inst_data[20], inst_data[30:21], 1'b0};

  // x0 is gated here as well, so a forced xreg[0] can never leak into results.
  assign rs1_val = (rs1 == 5'd0) ? 32'd0 : xreg[rs1];
  assign rs2_val = (rs2 == 5'd0) ? 32'd0 : xreg[rs2];

  assign ea_i = rs1_val + imm_i;
  assign ea   = (opcode == OPC_STORE) ? (rs1_val + imm_s) : ea_i;

  // funct7 bit 5 only means SUB/SRA for OP, and for the OP-IMM shift-right;
  // for ADDI etc. that bit belongs to the immediate.
  assign alu_b   = (opcode == OPC_OP) ? rs2_val : imm_i;
  assign alu_alt = ((opcode == OPC_OP) || (funct3 == ALU_SR)) ? inst_data[30] : 1'b0;

  assign op_valid = (funct7 == 7'h00) ||
                    ((funct7 == 7'h20) && ((funct3 == ALU_ADD) || (funct3 == ALU_SR)));
  assign opimm_valid = (funct3 == ALU_SLL) ? (funct7 == 7'h00) :
                       (funct3 == ALU_SR)  ? ((funct7 == 7'h00) || (funct7 == 7'h20)) :
                       1'b1;
  assign load_valid = (funct3 == F3_LB) || (funct3 == F3_LH) || (funct3 == F3_LW) ||
                      (funct3 == F3_LBU) || (funct3 == F3_LHU);

  riscv_alu u_alu (
    .a_i      (rs1_val),
    .b_i      (alu_b),
    .funct3_i (funct3),
    .alt_i    (alu_alt),
    .result_o (alu_res)
  );

  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [2:0]  f3,
                                               input logic [1:0]  lane);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (f3)
      F3_LB:   r = {{24{b[7]}}, b};
      F3_LH:   r = {{16{h[15]}}, h};
      F3_LBU:  r = {24'b0, b};
      F3_LHU:  r = {16'b0, h};
      default: r = word;
    endcase
    return r;
  endfunction

  always_comb begin
    br_valid = 1'b1;
    br_taken = 1'b0;
    case (funct3)
      F3_BEQ:  br_taken = (rs1_val == rs2_val);
      F3_BNE:  br_taken = (rs1_val != rs2_val);
      F3_BLT:  br_taken = ($signed(rs1_val) < $signed(rs2_val));
      F3_BGE:  br_taken = ($signed(rs1_val) >= $signed(rs2_val));
      F3_BLTU: br_taken = (rs1_val < rs2_val);
      F3_BGEU: br_taken = (rs1_val >= rs2_val);
      default: br_valid = 1'b0;
    endcase
  end

  // Next-state / datapath control.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc + 32'd4;
    rd_we       = 1'b0;
    rd_wdata    = '0;
    wr_idx      = rd;
    load_start  = 1'b0;
    store_lanes = '0;
    if (state_q == LOAD_WB) begin
      wr_idx   = ld_rd_q;
      rd_we    = 1'b1;
      rd_wdata = load_extract(data_rd, ld_f3_q, ld_lane_q);
      state_d  = EXEC;
    end else begin
      case (opcode)
        OPC_LUI: begin
          rd_we    = 1'b1;
          rd_wdata = imm_u;
        end
        OPC_AUIPC: begin
          rd_we    = 1'b1;
          rd_wdata = pc + imm_u;
        end
        OPC_JAL: begin
          rd_we    = 1'b1;
          rd_wdata = pc + 32'd4;
          pc_d     = pc + imm_j;
        end
        OPC_JALR: begin
          if (funct3 == 3'b000) begin
            rd_we    = 1'b1;
            rd_wdata = pc + 32'd4;
            pc_d     = {ea_i[31:1], 1'b0};
          end
        end
        OPC_BRANCH: begin
          if (br_valid && br_taken) pc_d = pc + imm_b;
        end
        OPC_LOAD: begin
          if (load_valid) begin
            load_start = 1'b1;
            pc_d       = pc;
            state_d    = LOAD_WB;
          end
        end
        OPC_STORE: begin
          case (funct3)
            F3_SB:   store_lanes = 4'b0001 << ea[1:0];
            F3_SH:   store_lanes = ea[1] ? 4'b1100 : 4'b0011;
            F3_SW:   store_lanes = 4'b1111;
            default: store_lanes = 4'b0000;
          endcase
        end
        OPC_OP_IMM: begin
          if (opimm_valid) begin
            rd_we    = 1'b1;
            rd_wdata = alu_res;
          end
        end
        OPC_OP: begin
          if (op_valid) begin
            rd_we    = 1'b1;
            rd_wdata = alu_res;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc      <= '0;
      state_q <= EXEC;
      for (int i = 0; i < 32; i++) xreg[i] <= '0;
    end else begin
      pc      <= pc_d;
      state_q <= state_d;
      if (rd_we && (wr_idx != 5'd0)) xreg[wr_idx] <= rd_wdata;
    end
  end

  // Load context is pure data; it is only meaningful once load_start fired.
  always_ff @(posedge clk) begin
    if (load_start) begin
      ld_f3_q   <= funct3;
      ld_lane_q <= ea[1:0];
      ld_rd_q   <= rd;
      ld_addr_q <= ea[31:2];
    end
  end

  assign inst_addr = pc;
  assign data_addr = (state_q == LOAD_WB) ? {2'b00, ld_addr_q} : {2'b00, ea[31:2]};

  always_comb begin
    case (funct3)
      F3_SB:   data_wr = {4{rs2_val[7:0]}};
      F3_SH:   data_wr = {2{rs2_val[15:0]}};
      default: data_wr = rs2_val;
    endcase
  end

  // Strobes are suppressed while reset is held so a store sitting on the
  // instruction port cannot corrupt RAM.
  assign data_wr_en = rst_n ? store_lanes : 4'b0000;

endmodule

// File: tb/tb_riscv_cpu.sv
module tb_riscv_cpu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] inst_data = 32'h0000_0013;
  logic [31:0] data_rd = 32'd0;
  logic [31:0] inst_addr, data_addr, data_wr;
  logic [3:0]  data_wr_en;

  riscv_cpu dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .inst_addr  (inst_addr),
    .inst_data  (inst_data),
    .data_addr  (data_addr),
    .data_rd    (data_rd),
    .data_wr    (data_wr),
    .data_wr_en (data_wr_en)
  );

  always #5 clk = ~clk;

  // Data RAM, owned by the stimulus process (written only through tick()).
  logic [31:0] ram [0:15];

  // ISA-level model state.
  logic [31:0] m_pc;
  logic [31:0] m_x [0:31];

  // Expected bus activity for the current cycle.
  logic        cmp_en = 1'b0;
  logic [3:0]  exp_we = 4'd0;
  logic        exp_mem = 1'b0;
  logic [31:0] exp_addr = 32'd0;
  logic [31:0] exp_wd = 32'd0;

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", name, act, exp);
  endtask

  // Per-cycle compare against the model's expected bus behaviour.
  always @(negedge clk) begin
    if (cmp_en && rst_n) begin
      check("inst_addr", inst_addr, m_pc);
      check("data_wr_en", {28'd0, data_wr_en}, {28'd0, exp_we});
      if (exp_mem) check("data_addr", data_addr, exp_addr);
      if (exp_we != 4'd0) check("data_wr", data_wr, exp_wd);
    end
  end

  // One clock of the synchronous RAM: sample bus before the edge, update after it.
  task automatic tick();
    logic [3:0]  we;
    logic [3:0]  a;
    logic [31:0] wd, rdv;
    @(negedge clk);
    we = data_wr_en; a = data_addr[3:0]; wd = data_wr;
    @(posedge clk);
    #1;
    rdv = ram[a];
    for (int i = 0; i < 4; i++) if (we[i]) ram[a][8*i +: 8] = wd[8*i +: 8];
    data_rd = rdv;
  endtask

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction

  function automatic logic [31:0] alu_m(input logic [2:0] f3, input logic [31:0] a,
                                        input logic [31:0] b, input logic alt);
    logic signed [31:0] sa;
    sa = a;
    case (f3)
      3'd0: return alt ? a - b : a + b;
      3'd1: return a << b[4:0];
      3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3: return (a < b) ? 32'd1 : 32'd0;
      3'd4: return a ^ b;
      3'd5: begin
        if (alt) return sa >>> b[4:0];
        return a >> b[4:0];
      end
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  // Execute one instruction on the model and run the DUT through it.
  task automatic exec(input logic [31:0] ins);
    logic [6:0]  op, f7;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [31:0] r1, r2, ii, is, ib, iu, ij, ea, nxt, val, w, sb, sh;
    logic        wr, ld, tk;
    op = ins[6:0]; rd = ins[11:7]; f3 = ins[14:12]; f7 = ins[31:25];
    r1 = m_x[ins[19:15]]; r2 = m_x[ins[24:20]];
    ii = {{20{ins[31]}}, ins[31:20]};
    is = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    ib = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
    iu = {ins[31:12], 12'd0};
    ij = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
    nxt = m_pc + 4; val = 0; wr = 0; ld = 0;
    exp_we = 0; exp_mem = 0; exp_addr = 0; exp_wd = 0;
    case (op)
      7'h37: begin wr = 1; val = iu; end
      7'h17: begin wr = 1; val = m_pc + iu; end
      7'h6f: begin wr = 1; val = m_pc + 4; nxt = m_pc + ij; end
      7'h67: if (f3 == 0) begin wr = 1; val = m_pc + 4; nxt = (r1 + ii) & ~32'd1; end
      7'h63: begin
        case (f3)
          3'd0: tk = (r1 == r2);
          3'd1: tk = (r1 != r2);
          3'd4: tk = ($signed(r1) < $signed(r2));
          3'd5: tk = ($signed(r1) >= $signed(r2));
          3'd6: tk = (r1 < r2);
          3'd7: tk = (r1 >= r2);
          default: tk = 0;
        endcase
        if (tk) nxt = m_pc + ib;
      end
      7'h03: if (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) begin
        ea = r1 + ii; ld = 1; wr = 1;
        exp_mem = 1; exp_addr = ea >> 2;
        w = ram[ea[5:2]];
        sb = w >> (8 * ea[1:0]);
        sh = w >> (16 * ea[1]);
        case (f3)
          3'd0: val = {{24{sb[7]}}, sb[7:0]};
          3'd1: val = {{16{sh[15]}}, sh[15:0]};
          3'd4: val = {24'd0, sb[7:0]};
          3'd5: val = {16'd0, sh[15:0]};
          default: val = w;
        endcase
      end
      7'h23: begin
        ea = r1 + is; exp_mem = 1; exp_addr = ea >> 2;
        case (f3)
          3'd0: begin exp_we = 4'b0001 << ea[1:0]; exp_wd = {4{r2[7:0]}}; end
          3'd1: begin exp_we = 4'b0011 << (2 * ea[1]); exp_wd = {2{r2[15:0]}}; end
          3'd2: begin exp_we = 4'b1111; exp_wd = r2; end
          default: exp_mem = 0;
        endcase
      end
      7'h13: begin
        if ((f3 == 1 && f7 == 0) || (f3 == 5 && (f7 == 0 || f7 == 7'h20)) || (f3 != 1 && f3 != 5)) begin
          wr = 1; val = alu_m(f3, r1, ii, (f3 == 5) && ins[30]);
        end
      end
      7'h33: begin
        if (f7 == 0 || (f7 == 7'h20 && (f3 == 0 || f3 == 5))) begin
          wr = 1; val = alu_m(f3, r1, r2, ins[30]);
        end
      end
      default: ;
    endcase
    inst_data = ins;
    tick();
    if (ld) begin
      exp_we = 0;
      tick();
    end
    m_pc = nxt;
    if (wr && rd != 0) m_x[rd] = val;
    check("pc", dut.pc, m_pc);
    if (wr && rd != 0) check("xreg", dut.xreg[rd], m_x[rd]);
  endtask

  task automatic set_reg(input logic [4:0] r, input logic [31:0] v);
    logic [31:0] up;
    up = (v + 32'h800) >> 12;
    exec({up[19:0], r, 7'h37});
    exec(enc_i(v[11:0], r, 3'd0, r, 7'h13));
  endtask

  task automatic do_reset();
    cmp_en = 0;
    rst_n = 0;
    inst_data = enc_s(12'd0, 5'd2, 5'd1, 3'd2);  // a store held during reset
    #2;
    check("rst pc", dut.pc, 32'd0);
    check("rst inst_addr", inst_addr, 32'd0);
    check("rst wr_en", {28'd0, data_wr_en}, 32'd0);
    tick();
    tick();
    rst_n = 1;
    m_pc = 0;
    for (int i = 0; i < 32; i++) m_x[i] = 0;
    cmp_en = 1;
  endtask

  logic [31:0] sb_exp [0:3];
  logic [31:0] lb_exp [0:3];
  logic [31:0] p_before;

  initial begin
    sb_exp[0] = 32'hFFFFFF01; sb_exp[1] = 32'hFFFF01FF;
    sb_exp[2] = 32'hFF01FFFF; sb_exp[3] = 32'h01FFFFFF;
    lb_exp[0] = 32'hFFFFFFC0; lb_exp[1] = 32'hFFFFFFB0;
    lb_exp[2] = 32'hFFFFFFA0; lb_exp[3] = 32'hFFFFFF90;
    for (int i = 0; i < 16; i++) ram[i] = 32'd0;
    for (int i = 0; i < 32; i++) m_x[i] = 0;
    m_pc = 0;

    do_reset();

    // NOP then addi
    exec(32'h0000_0013);
    check("nop pc", dut.pc, 32'd4);
    exec(32'h0340_0093);
    check("addi x1", dut.xreg[1], 32'h34);

    // Store lanes
    set_reg(5'd2, 32'd1);
    for (int a = 0; a < 4; a++) begin
      set_reg(5'd1, a);
      ram[0] = 32'hFFFF_FFFF;
      exec(enc_s(12'd0, 5'd2, 5'd1, 3'd0));
      check("sb lane", ram[0], sb_exp[a]);
    end
    set_reg(5'd1, 32'd0);
    ram[0] = 32'hFFFF_FFFF;
    exec(enc_s(12'd0, 5'd2, 5'd1, 3'd1));
    check("sh lo", ram[0], 32'hFFFF0001);
    set_reg(5'd1, 32'd2);
    ram[0] = 32'hFFFF_FFFF;
    exec(enc_s(12'd0, 5'd2, 5'd1, 3'd1));
    check("sh hi", ram[0], 32'h0001FFFF);
    set_reg(5'd1, 32'd0);
    ram[0] = 32'hFFFF_FFFF;
    exec(enc_s(12'd0, 5'd2, 5'd1, 3'd2));
    check("sw", ram[0], 32'h00000001);

    // Loads
    ram[0] = 32'h90A0B0C0;
    for (int k = 0; k < 4; k++) begin
      exec(enc_i(k, 5'd0, 3'd0, 5'd6, 7'h03));
      check("lb", dut.xreg[6], lb_exp[k]);
    end
    exec(enc_i(12'd3, 5'd0, 3'd4, 5'd6, 7'h03));
    check("lbu 3", dut.xreg[6], 32'h90);
    ram[0] = 32'h91A1B1C1;
    exec(enc_i(12'd2, 5'd0, 3'd5, 5'd6, 7'h03));
    check("lhu 2", dut.xreg[6], 32'h91A1);
    exec(enc_i(12'd0, 5'd0, 3'd2, 5'd6, 7'h03));
    check("lw", dut.xreg[6], 32'h91A1B1C1);
    exec(enc_i(12'd1, 5'd0, 3'd1, 5'd6, 7'h03));  // lh at odd offset uses lane by EA[1]

    // Endianness
    set_reg(5'd7, 32'h01020304);
    exec(enc_s(12'd0, 5'd7, 5'd0, 3'd2));
    for (int k = 0; k < 4; k++) begin
      exec(enc_i(k, 5'd0, 3'd4, 5'd6, 7'h03));
      check("endian lbu", dut.xreg[6], 32'd4 - k);
    end
    exec(enc_i(12'd0, 5'd0, 3'd5, 5'd6, 7'h03));
    check("endian lhu", dut.xreg[6], 32'h0304);

    // ALU
    set_reg(5'd8, 32'h80000010);
    set_reg(5'd9, 32'd4);
    exec(enc_r(7'h20, 5'd9, 5'd8, 3'd5, 5'd10));
    check("sra", dut.xreg[10], 32'hF8000001);
    exec(enc_r(7'h00, 5'd9, 5'd8, 3'd0, 5'd11));
    exec(enc_r(7'h20, 5'd9, 5'd8, 3'd0, 5'd12));
    check("sub", dut.xreg[12], 32'h8000000C);
    exec(enc_r(7'h00, 5'd9, 5'd8, 3'd2, 5'd13));
    check("slt", dut.xreg[13], 32'd1);
    exec(enc_r(7'h00, 5'd9, 5'd8, 3'd3, 5'd14));
    exec(enc_i(12'hFFF, 5'd8, 3'd3, 5'd15, 7'h13));
    exec(enc_i({7'h20, 5'd4}, 5'd8, 3'd5, 5'd16, 7'h13));
    exec(enc_i(12'd3, 5'd9, 3'd1, 5'd17, 7'h13));
    exec(enc_r(7'h00, 5'd9, 5'd8, 3'd4, 5'd18));
    exec(32'hFFFF_FFFF);  // unsupported encoding: NOP

    // Jumps
    p_before = dut.pc;
    exec(32'hFEDFF06F);
    check("jal -20", dut.pc, p_before - 32'd20);
    set_reg(5'd2, 32'h12345678);
    set_reg(5'd5, 32'h90909090);
    exec(enc_i(12'd0, 5'd5, 3'd0, 5'd0, 7'h67));
    check("jalr to", dut.pc, 32'h90909090);
    exec(enc_i(12'd0, 5'd2, 3'd0, 5'd3, 7'h67));
    check("jalr link", dut.xreg[3], 32'h90909094);
    check("jalr pc", dut.pc, 32'h12345678);

    // Branches from pc=0
    do_reset();
    set_reg(5'd4, 32'd1);
    exec(32'h0000_0067);
    exec(32'h0052_0863);
    check("beq ne", dut.pc, 32'h4);
    exec(32'h0000_0067);
    exec(32'h0052_1863);
    check("bne ne", dut.pc, 32'h10);
    set_reg(5'd5, 32'd1);
    exec(32'h0000_0067);
    exec(32'h0052_0863);
    check("beq eq", dut.pc, 32'h10);
    exec(32'h0000_0067);
    exec(32'h0052_1863);
    check("bne eq", dut.pc, 32'h4);

    // Reset in the middle of a load
    cmp_en = 0;
    inst_data = enc_i(12'd0, 5'd0, 3'd2, 5'd6, 7'h03);
    tick();
    check("ld pc hold", dut.pc, 32'h4);
    #1;
    rst_n = 0;
    #1;
    check("midload pc", dut.pc, 32'd0);
    check("midload wr_en", {28'd0, data_wr_en}, 32'd0);
    check("midload x4", dut.xreg[4], 32'd0);
    do_reset();
    exec(32'h0000_0013);
    check("post-reset nop", dut.pc, 32'd4);
    check("no wb", dut.xreg[6], 32'd0);

    cmp_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
